// File: rtl/axil_wr_arbiter_if.sv
// Bus bundle between the requesters, the round-robin write arbiter and the
// shared AXI-lite write master.
interface axil_wr_arbiter_if #(
   parameter int N    = 32,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] req_addr;
   logic [NREQ*N-1:0] req_data;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   ack;
   logic [N-1:0]      m_addr;
   logic [N-1:0]      m_data;
   logic              m_start;
   logic              m_done;

   // Arbiter side: drives grants, acks and the master command.
   modport master (
      input  req, req_addr, req_data, m_done,
      output gnt, ack, m_addr, m_data, m_start
   );

   // Environment side: requesters plus the write master.
   modport slave (
      output req, req_addr, req_data, m_done,
      input  gnt, ack, m_addr, m_data, m_start
   );
endinterface

// File: rtl/axil_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-lite write master among NREQ requesters,
// with a completed-transaction counter and a sticky watchdog flag.
module axil_wr_arbiter #(
   parameter int N       = 32,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024,
   parameter int CNTW    = 16
) (
   input  logic                 CLK,
   input  logic                 R,
   axil_wr_arbiter_if.master    bus,
   output logic                 busy,
   output logic [CNTW-1:0]      txn_count,
   output logic                 timeout_err
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
   localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT);
   localparam logic [WDW-1:0]  WD_ONE   = WDW'(1'b1);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1'b1);
   localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1'b1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      ACK    = 2'd3
   } state_t;

   state_t          state_r;
   logic [PW-1:0]   ptr_r;
   logic [PW-1:0]   win_r;
   logic [WDW-1:0]  wd_r;
   logic [NREQ-1:0] gnt_r;
   logic [NREQ-1:0] ack_r;
   logic [N-1:0]    m_addr_r;
   logic [N-1:0]    m_data_r;
   logic            m_start_r;
   logic            busy_r;
   logic [CNTW-1:0] cnt_r;
   logic            tmo_r;

   logic [PW-1:0]   pick_s;
   logic            any_s;
   int              idx_s;

   // Round-robin pick: first set request at or above ptr_r, wrapping at NREQ.
   always_comb begin
      pick_s = '0;
      any_s  = 1'b0;
      idx_s  = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = int'(ptr_r) + k;
         if (idx_s >= NREQ) begin
            idx_s = idx_s - NREQ;
         end else begin
            idx_s = idx_s;
         end
         if (!any_s && bus.req[idx_s]) begin
            any_s  = 1'b1;
            pick_s = PW'(idx_s);
         end else begin
            any_s  = any_s;
         end
      end
   end

   // Arbitration FSM, master command registers, counter and watchdog.
   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         state_r   <= IDLE;
         ptr_r     <= '0;
         win_r     <= '0;
         wd_r      <= '0;
         gnt_r     <= '0;
         ack_r     <= '0;
         m_addr_r  <= '0;
         m_data_r  <= '0;
         m_start_r <= 1'b0;
         busy_r    <= 1'b0;
         cnt_r     <= '0;
         tmo_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  win_r    <= pick_s;
                  gnt_r    <= GNT_ONE << pick_s;
                  m_addr_r <= bus.req_addr[int'(pick_s)*N +: N];
                  m_data_r <= bus.req_data[int'(pick_s)*N +: N];
                  busy_r   <= 1'b1;
                  state_r  <= LAUNCH;
               end
            end
            LAUNCH: begin
               m_start_r <= 1'b1;
               wd_r      <= '0;
               state_r   <= WAIT;
            end
            WAIT: begin
               m_start_r <= 1'b0;
               // Completion takes precedence over a watchdog expiring on the same edge.
               if (bus.m_done) begin
                  ack_r   <= gnt_r;
                  cnt_r   <= cnt_r + CNT_ONE;
                  ptr_r   <= (win_r == PTR_LAST) ? '0 : win_r + PTR_ONE;
                  state_r <= ACK;
               end else begin
                  if (wd_r != WD_MAX) begin
                     wd_r <= wd_r + WD_ONE;
                  end
                  if ((TIMEOUT != 0) && (wd_r == WD_MAX - WD_ONE)) begin
                     tmo_r <= 1'b1;
                  end
               end
            end
            ACK: begin
               ack_r   <= '0;
               gnt_r   <= '0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ack_r     <= '0;
               gnt_r     <= '0;
               busy_r    <= 1'b0;
               m_start_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.ack     = ack_r;
   assign bus.m_addr  = m_addr_r;
   assign bus.m_data  = m_data_r;
   assign bus.m_start = m_start_r;
   assign busy        = busy_r;
   assign txn_count   = cnt_r;
   assign timeout_err = tmo_r;

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Self-checking bench for axil_wr_arbiter: vector table of request patterns with
// a grant-order scoreboard, plus hand sequences for watchdog, reset and idle m_done.
module tb_axil_wr_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;

   logic CLK = 1'b0;
   logic R   = 1'b1;
   always #5 CLK = ~CLK;

   axil_wr_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
   axil_wr_arbiter_if #(.N(N), .NREQ(NREQ)) bus_b ();

   logic        busy, timeout_err, busy_b, tmo_b;
   logic [15:0] txn_count;
   logic [1:0]  txn_b;

   // Second instance sees identical stimulus; only its 2-bit counter is checked.
   assign bus_b.req      = bus.req;
   assign bus_b.req_addr = bus.req_addr;
   assign bus_b.req_data = bus.req_data;
   assign bus_b.m_done   = bus.m_done;

   axil_wr_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(8), .CNTW(16)) dut (
      .CLK(CLK), .R(R), .bus(bus),
      .busy(busy), .txn_count(txn_count), .timeout_err(timeout_err)
   );

   axil_wr_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(8), .CNTW(2)) dut_b (
      .CLK(CLK), .R(R), .bus(bus_b),
      .busy(busy_b), .txn_count(txn_b), .timeout_err(tmo_b)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] hold;
      logic [3:0] late;
      bit         drop;
      int         lat;
      int         n;
      int         order [4];
   } vec_t;

   vec_t vecs [6];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int sb_q [$];
   logic [31:0] addr_tab [4];
   logic [31:0] data_tab [4];
   logic [3:0]  req_v = 4'b0000;
   logic [3:0]  hold_v = 4'b0000;
   logic [3:0]  late_req = 4'b0000;
   bit          drop_mid = 1'b0;
   int          lat = 3;
   int          mcnt = 0;
   bit          in_txn = 1'b0;
   bit          prev_ack = 1'b0;
   int          cur_idx = 0;
   int          exp_cnt = 0;
   int          n_ack = 0;
   int          target = 0;
   int          t_first = 0;
   int          c0 = 0;
   logic [31:0] hold_addr, hold_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic init_tabs();
      addr_tab[0] = 32'h0000_0010;
      data_tab[0] = 32'h0000_A5A5;
      for (int i = 1; i < NREQ; i++) begin
         addr_tab[i] = 32'h1000_0000 + 32'h100 * i;
         data_tab[i] = 32'hC0DE_0000 + i;
      end
   endtask

   task automatic drive();
      bus.req = req_v;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i*N +: N] = addr_tab[i];
         bus.req_data[i*N +: N] = data_tab[i];
      end
   endtask

   task automatic set_vec(input int i, input logic [3:0] rq, input logic [3:0] hd,
                          input logic [3:0] lt, input bit dr, input int lt_cyc,
                          input int n, input int o0, input int o1, input int o2, input int o3);
      vecs[i].req  = rq;
      vecs[i].hold = hd;
      vecs[i].late = lt;
      vecs[i].drop = dr;
      vecs[i].lat  = lt_cyc;
      vecs[i].n    = n;
      vecs[i].order[0] = o0;
      vecs[i].order[1] = o1;
      vecs[i].order[2] = o2;
      vecs[i].order[3] = o3;
   endtask

   // One cycle: observe DUT at the falling edge, run requester/master models, drive inputs.
   task automatic step();
      @(negedge CLK);
      cyc++;
      if (bus.ack !== 4'b0000) begin
         n_ack++;
         exp_cnt++;
         chk("ack_owner", bus.ack, 4'b0001 << cur_idx);
         chk("txn_count", txn_count, exp_cnt & 16'hFFFF);
         chk("txn_count_wrap2", txn_b, exp_cnt % 4);
         chk("ack_busy", busy, 1'b1);
         chk("ack_single_cycle", prev_ack, 1'b0);
         in_txn = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i] === 1'b1) begin
               if (hold_v[i]) hold_v[i] = 1'b0;
               else req_v[i] = 1'b0;
            end
         end
      end
      prev_ack = (bus.ack !== 4'b0000);
      if (bus.m_start === 1'b1) begin
         if (t_first == 0) t_first = cyc;
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_start: got m_start=1 required no start (cycle %0d)", cyc);
            cur_idx = 0;
         end else begin
            cur_idx = sb_q.pop_front();
            chk("start_gnt", bus.gnt, 4'b0001 << cur_idx);
            chk("start_addr", bus.m_addr, addr_tab[cur_idx]);
            chk("start_data", bus.m_data, data_tab[cur_idx]);
            chk("start_busy", busy, 1'b1);
         end
         hold_addr = bus.m_addr;
         hold_data = bus.m_data;
         in_txn = 1'b1;
         mcnt = lat;
         // Change the winner's inputs so a DUT that re-samples them is caught.
         addr_tab[cur_idx] = addr_tab[cur_idx] + 32'h4;
         data_tab[cur_idx] = ~data_tab[cur_idx];
         req_v = req_v | late_req;
         late_req = 4'b0000;
         if (drop_mid) begin
            req_v[cur_idx] = 1'b0;
            drop_mid = 1'b0;
         end
      end else if (in_txn) begin
         chk("hold_addr", bus.m_addr, hold_addr);
         chk("hold_data", bus.m_data, hold_data);
      end
      if (mcnt > 0) begin
         mcnt--;
         bus.m_done = (mcnt == 0);
      end else begin
         bus.m_done = 1'b0;
      end
      drive();
   endtask

   task automatic wait_acks();
      for (int g = 0; g < 400 && n_ack < target; g++) step();
      chk("ack_count", n_ack, target);
   endtask

   task automatic wait_start();
      for (int g = 0; g < 20 && t_first == 0; g++) step();
      chk("start_latency", t_first - c0, 2);
   endtask

   task automatic launch(input logic [3:0] rq);
      req_v = rq;
      t_first = 0;
      c0 = cyc;
      drive();
   endtask

   initial begin
      init_tabs();
      bus.m_done = 1'b0;
      drive();
      set_vec(0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 3, 4, 0, 1, 2, 3);
      set_vec(1, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4, 2, 0, 2, 0, 0);
      set_vec(2, 4'b0010, 4'b0010, 4'b1000, 1'b0, 3, 3, 1, 3, 1, 0);
      set_vec(3, 4'b0100, 4'b0000, 4'b0000, 1'b1, 5, 1, 2, 0, 0, 0);
      set_vec(4, 4'b0001, 4'b0000, 4'b0000, 1'b0, 8, 1, 0, 0, 0, 0);
      set_vec(5, 4'b1001, 4'b0000, 4'b0000, 1'b0, 2, 2, 3, 0, 0, 0);

      repeat (3) @(negedge CLK);
      chk("rst_gnt", bus.gnt, 4'b0000);
      chk("rst_ack", bus.ack, 4'b0000);
      chk("rst_m_addr", bus.m_addr, 32'h0);
      chk("rst_m_data", bus.m_data, 32'h0);
      chk("rst_m_start", bus.m_start, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_txn_count", txn_count, 16'h0);
      chk("rst_timeout", timeout_err, 1'b0);
      R = 1'b0;
      step();

      for (int v = 0; v < 6; v++) begin
         lat = vecs[v].lat;
         hold_v = vecs[v].hold;
         late_req = vecs[v].late;
         drop_mid = vecs[v].drop;
         for (int j = 0; j < vecs[v].n; j++) sb_q.push_back(vecs[v].order[j]);
         target = n_ack + vecs[v].n;
         launch(vecs[v].req);
         wait_start();
         wait_acks();
         step();
         step();
         chk("idle_busy", busy, 1'b0);
         chk("idle_gnt", bus.gnt, 4'b0000);
         chk("sb_drained", sb_q.size(), 0);
         chk("no_timeout", timeout_err, 1'b0);
      end

      // m_done while idle must be ignored.
      bus.m_done = 1'b1;
      step();
      step();
      chk("idle_done_ack", bus.ack, 4'b0000);
      chk("idle_done_busy", busy, 1'b0);
      chk("idle_done_count", txn_count, exp_cnt & 16'hFFFF);

      // Stalled master: watchdog fires 8 cycles after WAIT entry, ack still follows.
      lat = 20;
      sb_q.push_back(3);
      target = n_ack + 1;
      launch(4'b1000);
      wait_start();
      while (cyc < t_first + 7) step();
      chk("tmo_before", timeout_err, 1'b0);
      step();
      chk("tmo_rise", timeout_err, 1'b1);
      wait_acks();
      step();
      chk("tmo_sticky", timeout_err, 1'b1);

      // Reset while waiting on the master.
      sb_q.push_back(0);
      launch(4'b0001);
      wait_start();
      step();
      step();
      #2 R = 1'b1;
      #1;
      chk("arst_gnt", bus.gnt, 4'b0000);
      chk("arst_m_addr", bus.m_addr, 32'h0);
      chk("arst_m_data", bus.m_data, 32'h0);
      chk("arst_m_start", bus.m_start, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_txn_count", txn_count, 16'h0);
      chk("arst_txn_count_b", txn_b, 2'b00);
      chk("arst_timeout", timeout_err, 1'b0);
      sb_q.delete();
      mcnt = 0;
      bus.m_done = 1'b0;
      in_txn = 1'b0;
      prev_ack = 1'b0;
      exp_cnt = 0;
      hold_v = 4'b0000;
      req_v = 4'b0000;
      init_tabs();
      drive();
      repeat (2) @(negedge CLK);
      R = 1'b0;
      step();

      lat = 3;
      sb_q.push_back(0);
      target = n_ack + 1;
      launch(4'b0001);
      wait_start();
      wait_acks();
      step();
      sb_q.push_back(2);
      target = n_ack + 1;
      launch(4'b0100);
      wait_start();
      wait_acks();
      step();
      step();
      chk("final_busy", busy, 1'b0);
      chk("final_count", txn_count, 16'h0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
